// File: rtl/ray_pkg.sv
// Shared types and constants for the ray pipeline receive path.
package ray_pkg;

    localparam int unsigned MAX_CORES = 4;
    localparam int unsigned COLOR_W   = 24;
    localparam int unsigned IDX_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } collector_state_t;

    typedef struct packed {
        logic [IDX_W-1:0]   index;
        logic [COLOR_W-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/pixel_slot.sv
// One-entry holding register for a single core's shaded pixel result.
module pixel_slot
    import ray_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   flush,
    input  logic   load,
    input  pixel_t load_pixel,
    input  logic   clear,
    output pixel_t pixel,
    output logic   full,
    output logic   ready
);

    pixel_t pixel_q, pixel_d;
    logic   full_q, full_d;
    logic   ready_q, ready_d;

    // Load and clear are mutually exclusive: load needs an empty slot, clear a full one.
    always_comb begin
        pixel_d = pixel_q;
        full_d  = full_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (load) begin
            pixel_d = load_pixel;
            full_d  = 1'b1;
        end else if (clear) begin
            full_d = 1'b0;
        end
        ready_d = ~full_d;
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            pixel_q <= '0;
            full_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            pixel_q <= pixel_d;
            full_q  <= full_d;
            ready_q <= ready_d;
        end
    end

    assign pixel = pixel_q;
    assign full  = full_q;
    assign ready = ready_q;

endmodule

// File: rtl/pixel_collector.sv
// Collects interleaved pixel results from up to four ray cores and re-emits
// them as a single raster-ordered stream with start-of-frame / end-of-line marks.
module pixel_collector
    import ray_pkg::*;
#(
    parameter int unsigned MAX_CORES = ray_pkg::MAX_CORES,
    parameter int unsigned COLOR_W   = ray_pkg::COLOR_W,
    parameter int unsigned IDX_W     = ray_pkg::IDX_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [1:0]                 op_code,
    input  logic [12:0]                image_width,
    input  logic [12:0]                image_height,
    input  logic [MAX_CORES-1:0]       in_valid,
    input  logic [MAX_CORES*IDX_W-1:0] in_index,
    input  logic [MAX_CORES*COLOR_W-1:0] in_color,
    output logic [MAX_CORES-1:0]       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLOR_W-1:0]         out_data,
    output logic                       out_sof,
    output logic                       out_last,
    output logic                       frame_done,
    output logic                       busy,
    output logic                       err
);

    localparam int unsigned RR_W  = 2;
    localparam int unsigned DIM_W = 13;
    localparam int unsigned TOT_W = 26;

    collector_state_t   state_q, state_d;
    logic [RR_W-1:0]    n_m1_q, n_m1_d;
    logic [RR_W-1:0]    rr_q, rr_d;
    logic [DIM_W-1:0]   w_q, w_d;
    logic [DIM_W-1:0]   col_q, col_d;
    logic [TOT_W-1:0]   total_q, total_d;
    logic [TOT_W-1:0]   e_q, e_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic [COLOR_W-1:0] out_data_q, out_data_d;
    logic               out_sof_q, out_sof_d;
    logic               out_last_q, out_last_d;
    logic               out_final_q, out_final_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;

    pixel_t             slot_pix [MAX_CORES];
    logic [MAX_CORES-1:0] slot_full;
    logic [MAX_CORES-1:0] slot_ready;
    logic [MAX_CORES-1:0] slot_load;
    logic [MAX_CORES-1:0] slot_pop;
    logic [MAX_CORES-1:0] core_act;
    logic               slot_flush;
    logic               drain;
    logic               load_out;
    logic [TOT_W-1:0]   start_total;

    // Per-core slots; ready decodes from registered state only.
    for (genvar i = 0; i < MAX_CORES; i++) begin : g_core
        pixel_t in_pix;

        assign in_pix.index  = in_index[i*IDX_W +: IDX_W];
        assign in_pix.colour = in_color[i*COLOR_W +: COLOR_W];
        assign core_act[i]   = (RR_W'(i) <= n_m1_q);
        assign in_ready[i]   = (state_q == RUN) && slot_ready[i] && core_act[i];
        assign slot_load[i]  = in_valid[i] && in_ready[i];

        pixel_slot u_slot (
            .clk        (clk),
            .reset_n    (reset_n),
            .flush      (slot_flush),
            .load       (slot_load[i]),
            .load_pixel (in_pix),
            .clear      (slot_pop[i]),
            .pixel      (slot_pix[i]),
            .full       (slot_full[i]),
            .ready      (slot_ready[i])
        );
    end

    assign drain = out_valid_q && out_ready;

    always_comb begin
        state_d      = state_q;
        n_m1_d       = n_m1_q;
        rr_d         = rr_q;
        w_d          = w_q;
        col_d        = col_q;
        total_d      = total_q;
        e_d          = e_q;
        err_d        = err_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sof_d    = out_sof_q;
        out_last_d   = out_last_q;
        out_final_d  = out_final_q;
        frame_done_d = 1'b0;
        slot_flush   = 1'b0;
        slot_pop     = '0;
        load_out     = 1'b0;
        start_total  = TOT_W'(image_width) * TOT_W'(image_height);

        case (state_q)
            IDLE: begin
                if (en) begin
                    n_m1_d     = op_code;
                    w_d        = image_width;
                    total_d    = start_total;
                    e_d        = '0;
                    col_d      = '0;
                    rr_d       = '0;
                    err_d      = 1'b0;
                    slot_flush = 1'b1;
                    if (start_total == '0) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (drain) begin
                    out_valid_d = 1'b0;
                    if (out_final_q) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end
                end
                // Never fetch past the final pixel of the frame.
                load_out = slot_full[rr_q] && (!out_valid_q || drain)
                           && !(out_valid_q && out_final_q);
                if (load_out) begin
                    out_valid_d    = 1'b1;
                    out_data_d     = slot_pix[rr_q].colour;
                    out_sof_d      = (e_q == '0);
                    out_last_d     = (col_q == w_q - DIM_W'(1));
                    out_final_d    = (e_q == total_q - TOT_W'(1));
                    slot_pop[rr_q] = 1'b1;
                    if (slot_pix[rr_q].index != IDX_W'(e_q)) begin
                        err_d = 1'b1;
                    end
                    rr_d  = (rr_q == n_m1_q) ? '0 : rr_q + RR_W'(1);
                    e_d   = e_q + TOT_W'(1);
                    col_d = (col_q == w_q - DIM_W'(1)) ? '0 : col_q + DIM_W'(1);
                end
            end

            DONE: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q      <= IDLE;
            n_m1_q       <= '0;
            rr_q         <= '0;
            w_q          <= '0;
            col_q        <= '0;
            total_q      <= '0;
            e_q          <= '0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sof_q    <= 1'b0;
            out_last_q   <= 1'b0;
            out_final_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_m1_q       <= n_m1_d;
            rr_q         <= rr_d;
            w_q          <= w_d;
            col_q        <= col_d;
            total_q      <= total_d;
            e_q          <= e_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_last_q   <= out_last_d;
            out_final_q  <= out_final_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sof    = out_sof_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pixel_collector.sv
// Directed scoreboard bench for pixel_collector: per-core feeders, output
// monitor with in-order expected queue and stall-stability checks.
module tb_pixel_collector;

    localparam int NC = 4;
    localparam int IW = 32;
    localparam int CW = 24;

    typedef struct {
        logic [IW-1:0] idx;
        logic [CW-1:0] col;
    } px_t;

    typedef struct {
        logic [CW-1:0] data;
        logic          sof;
        logic          last;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             en;
    logic [1:0]       op_code;
    logic [12:0]      image_width;
    logic [12:0]      image_height;
    logic [NC-1:0]    in_valid;
    logic [NC*IW-1:0] in_index;
    logic [NC*CW-1:0] in_color;
    logic [NC-1:0]    in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_data;
    logic             out_sof;
    logic             out_last;
    logic             frame_done;
    logic             busy;
    logic             err;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   n_px = 0;
    int   core_hold [NC];
    int   rdy_mode = 0;
    int   rdy_cnt = 0;
    px_t  core_q [NC][$];
    exp_t exp_q [$];
    exp_t ev;
    logic [NC-1:0] acc;
    logic          stalled = 1'b0;
    logic [CW-1:0] hold_data;
    logic          hold_sof;
    logic          hold_last;

    pixel_collector dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .op_code      (op_code),
        .image_width  (image_width),
        .image_height (image_height),
        .in_valid     (in_valid),
        .in_index     (in_index),
        .in_color     (in_color),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sof      (out_sof),
        .out_last     (out_last),
        .frame_done   (frame_done),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Core feeders and downstream ready pattern, updated just after each edge.
    always begin
        @(negedge clk);
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (acc[i] === 1'b1 && core_q[i].size() > 0) void'(core_q[i].pop_front());
            if (core_hold[i] > 0) core_hold[i]--;
            if (core_q[i].size() > 0 && core_hold[i] == 0) begin
                in_valid[i]            = 1'b1;
                in_index[i*IW +: IW]   = core_q[i][0].idx;
                in_color[i*CW +: CW]   = core_q[i][0].col;
            end else begin
                in_valid[i] = 1'b0;
            end
        end
        out_ready = (rdy_mode == 0) || (rdy_cnt == 0);
        rdy_cnt   = (rdy_cnt + 1) % 3;
    end

    // Output monitor: scoreboard compare on handshake, stability while stalled.
    always @(negedge clk) begin
        if (reset_n !== 1'b0) begin
            stalled = 1'b0;
        end else begin
            if (frame_done === 1'b1) n_done++;
            if (out_valid === 1'b1 && stalled) begin
                check("stall_data", 32'(out_data), 32'(hold_data));
                check("stall_sof", 32'(out_sof), 32'(hold_sof));
                check("stall_last", 32'(out_last), 32'(hold_last));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    ev = exp_q.pop_front();
                    check("pix_data", 32'(out_data), 32'(ev.data));
                    check("pix_sof", 32'(out_sof), 32'(ev.sof));
                    check("pix_last", 32'(out_last), 32'(ev.last));
                end
                n_px++;
                stalled = 1'b0;
            end else if (out_valid === 1'b1) begin
                stalled   = 1'b1;
                hold_data = out_data;
                hold_sof  = out_sof;
                hold_last = out_last;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic start_frame(input int n, input int w, input int h,
                               input int bad_px, input int bad_idx);
        px_t  px;
        exp_t ex;
        for (int p = 0; p < w * h; p++) begin
            px.idx  = (p == bad_px) ? 32'(bad_idx) : 32'(p);
            px.col  = 24'(16 + p);
            core_q[p % n].push_back(px);
            ex.data = 24'(16 + p);
            ex.sof  = (p == 0);
            ex.last = ((p % w) == w - 1);
            exp_q.push_back(ex);
        end
        @(posedge clk); #1;
        en           = 1'b1;
        op_code      = 2'(n - 1);
        image_width  = 13'(w);
        image_height = 13'(h);
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input logic exp_err);
        int cyc = 0;
        while (n_done == base && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(n_done > base), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_done_once"}, 32'(n_done), 32'(base + 1));
        check({tag, "_all_out"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_sof"}, 32'(out_sof), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset_n      = 1'b1;
        en           = 1'b0;
        op_code      = 2'd0;
        image_width  = 13'd0;
        image_height = 13'd0;
        in_valid     = '0;
        in_index     = '0;
        in_color     = '0;
        out_ready    = 1'b1;
        for (int i = 0; i < NC; i++) core_hold[i] = 0;

        repeat (3) begin @(posedge clk); #1; end
        check_reset_outputs("reset");
        reset_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Single core, 4x2, ready always high.
        base = n_done;
        start_frame(1, 4, 2, -1, 0);
        wait_done("n1", base, 1'b0);

        // Four cores, core 3 first and core 0 last.
        core_hold[0] = 9; core_hold[1] = 6; core_hold[2] = 3; core_hold[3] = 0;
        base = n_done;
        start_frame(4, 4, 2, -1, 0);
        repeat (3) begin @(posedge clk); #1; end
        check("n4_core3_ready_low", 32'(in_ready[3]), 32'd0);
        check("n4_waiting_core0", 32'(out_valid), 32'd0);
        wait_done("n4", base, 1'b0);

        // Two cores, 3x3, downstream ready 1 cycle in 3.
        rdy_mode = 1;
        base = n_done;
        start_frame(2, 3, 3, -1, 0);
        wait_done("n2_stall", base, 1'b0);
        rdy_mode = 0;

        // Core 1 sends index 5 where 3 is expected.
        base = n_done;
        start_frame(2, 2, 2, 3, 5);
        wait_done("mismatch", base, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        check("err_sticky", 32'(err), 32'd1);

        // Abort after three pixels, then a fresh three-core frame.
        base = n_done;
        start_frame(1, 4, 2, -1, 0);
        check("err_cleared_on_start", 32'(err), 32'd0);
        begin
            int px0 = n_px - 0;
            int cyc = 0;
            px0 = n_px;
            while (n_px < px0 + 3 && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("abort_three_seen", 32'(n_px - px0), 32'd3);
        end
        reset_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NC; i++) core_q[i].delete();
        @(posedge clk); #1;
        check_reset_outputs("abort");
        reset_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("abort_no_done", 32'(n_done), 32'(base));
        start_frame(3, 2, 3, -1, 0);
        wait_done("after_abort", base, 1'b0);

        // Zero-width frame: straight to DONE.
        base = n_done;
        start_frame(1, 0, 5, -1, 0);
        check("w0_busy", 32'(busy), 32'd1);
        check("w0_frame_done", 32'(frame_done), 32'd1);
        check("w0_no_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("w0_busy_drop", 32'(busy), 32'd0);
        check("w0_done_drop", 32'(frame_done), 32'd0);
        check("w0_no_valid2", 32'(out_valid), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        check("w0_done_once", 32'(n_done), 32'(base + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_collector.md
# pixel_collector

Receiving end of the ray pipeline. Accepts shaded pixel results from up to four ray cores and reorders them into raster order. Core `c` processes pixel indices `c, c+N, c+2N, …`, where `N = op_code+1`. The block returns per-core ready (driven into each core's `ready_internal`) and emits one registered valid/ready pixel stream toward the framebuffer/video writer, with start-of-frame and end-of-line markers.

## Interface
Parameters:
- `MAX_CORES`, 4: core slots instantiated; fixed by 2-bit `op_code`
- `COLOR_W`, 24: pixel colour width (RGB888)
- `IDX_W`, 32: pixel index width, same as the core `loop_index`

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  reset: synchronous, active-high (name kept per codebase; asserted = 1)
- `en`  in  1  start-of-frame request, sampled only in IDLE
- `op_code`  in  2  active cores, `N = op_code+1` (1..4), latched at start
- `image_width`, `image_height`  in  13 each  frame size, latched at start
- `in_valid`  in  MAX_CORES  per-core result valid
- `in_index`  in  MAX_CORES*IDX_W  per-core pixel index, core `i` at `[i*IDX_W +: IDX_W]`
- `in_color`  in  MAX_CORES*COLOR_W  per-core colour
- `in_ready`  out  MAX_CORES  per-core accept, to the core `ready_internal`
- `out_valid`  out  1  output pixel valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  COLOR_W  pixel colour
- `out_sof`  out  1  high with pixel index 0
- `out_last`  out  1  high on the last pixel of each line
- `frame_done`  out  1  one-cycle pulse after the last pixel is accepted
- `busy`  out  1  high in any state except IDLE
- `err`  out  1  sticky index-mismatch flag, cleared by reset or by the next start

## Operation
- States: IDLE, RUN, DONE. Encoding 0, 1, 2.
- IDLE → RUN on `en`:
  - latch `N`, `W`, `H`, and `total = W*H` (26 bits)
  - clear expected index `e`, column counter `col`, round-robin pointer `rr`, `err`, and all slots
- IDLE → DONE directly if `en` and `total == 0`.
- `en` is ignored outside IDLE.
- Each core `i` has a one-entry slot holding {index, colour, full}.
- `in_ready[i] = (state==RUN) && !slot[i].full && (i < N)`, decoded from registers only, with no combinational path from `in_valid` or `out_ready`.
- Cores `i >= N` have `in_ready=0` and their `in_valid` is ignored.
- Capture into slot `i` on `in_valid[i] && in_ready[i]`.
- Output register loads from `slot[rr]` when:
  - `slot[rr].full`, and
  - the output register is empty or is being drained (`out_valid && out_ready`) this cycle.
- On each load:
  - `out_data = colour`, `out_sof = (e==0)`, `out_last = (col==W-1)`
  - slot `rr` is cleared
  - `rr = (rr+1) mod N`
  - `e += 1`
  - `col` wraps to 0 after `W-1`
- Index mismatch: if the loaded `slot[rr].index != e`, set `err`. The pixel is still emitted and the stream continues in position order.
- RUN → DONE when the output register drains the pixel with `e_emitted == total-1`.
- DONE: `frame_done=1` for exactly one cycle, then → IDLE.
- Arithmetic: `e` and `total` are unsigned 26 bits; the index compare zero-extends to `IDX_W`. `W=1` gives `out_last` on every pixel.

## Timing
- Reset values: state IDLE, all slots empty, `in_ready=0`, `out_valid=0`, `out_data=0`, `out_sof=0`, `out_last=0`, `frame_done=0`, `busy=0`, `err=0`.
- Reset asserted mid-frame aborts at the next edge. No `frame_done` is produced and in-flight pixels are discarded.
- Latency: input handshake at edge `t` → slot full after `t` → `out_valid` after `t+1`, i.e. 2 cycles minimum.
- Slot refill: a slot emptied at edge `t` raises `in_ready` for cycle `t+1`.
- Throughput: `N=1` gives at most 1 pixel per 2 cycles; `N>=2` sustains 1 pixel/cycle with `out_ready` held high.
- `out_valid` holds with stable `out_data/out_sof/out_last` until `out_ready`.
- Simultaneous drain and load of the output register in the same cycle is allowed; no bubble.
- Slots fill while `out_ready=0`. Once all `N` slots are full, all `in_ready` are low.

## Structure
- Shared package `ray_pkg` holds:
  - `collector_state_t` enum {IDLE, RUN, DONE}
  - `MAX_CORES`, `COLOR_W`, `IDX_W` constants
  - the `pixel_t` struct {index, colour}
- Sub-module `pixel_slot`: one-entry holding register with full flag, load/clear ports, and `ready` output; instantiated `MAX_CORES` times.

## Test plan
- `N=1`, `W=4`, `H=2`, indices 0..7, colours `0x000010+i`, `out_ready=1` → 8 pixels in order, `out_sof` on pixel 0, `out_last` on pixels 3 and 7, one `frame_done`, `err=0`.
- `N=4`, `W=4`, `H=2`, core 3 delivers first and core 0 last → output still `0x10..0x17` in order; `in_ready[3]` low after capture until drained.
- `N=2`, `W=3`, `H=3`, `out_ready` toggled 1-of-3 → no loss or duplication, output stable while stalled, 9 pixels, `frame_done` once.
- `N=2`, core 1 sends index 5 where 3 is expected → `err=1` sticky, pixel still emitted, `err` cleared by next `en`.
- Reset asserted after 3 of 8 pixels → next cycle all outputs at reset values; a new frame afterwards completes normally.
- `W=0`, `en` pulse → `busy` one cycle, `frame_done` pulse, no `out_valid`.
